// File: rtl/expr_stream_checker_pkg.sv
// Shared types and ASCII constants for the expression stream checker and
// any later tokenizers that reuse its character classifier.
package expr_pkg;

    typedef enum logic [2:0] {
        S_OPND,
        S_NUM,
        S_ZERO,
        S_CLOSE,
        S_ERR
    } state_e;

    typedef enum logic [2:0] {
        CC_NZ,
        CC_ZERO,
        CC_OP,
        CC_OPEN,
        CC_CLOSE,
        CC_NUL,
        CC_BAD
    } charClass_e;

    localparam logic [7:0] ASCII_0      = 8'h30;
    localparam logic [7:0] ASCII_9      = 8'h39;
    localparam logic [7:0] ASCII_LPAREN = 8'h28;
    localparam logic [7:0] ASCII_RPAREN = 8'h29;
    localparam logic [7:0] ASCII_PLUS   = 8'h2B;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_MINUS  = 8'h2D;
    localparam logic [7:0] ASCII_NUL    = 8'h00;

endpackage

// File: rtl/expr_stream_checker_if.sv
// Byte-stream bus between a character source (master) and the checker (slave).
interface expr_stream_checker_if #(
    parameter int MAX_DEPTH = 4,
    parameter int POS_W     = 8
);
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

    logic               restart;
    logic               in_valid;
    logic [7:0]         in;
    logic               out;
    logic               err;
    logic [POS_W-1:0]   err_pos;
    logic [DEPTH_W-1:0] depth;
    logic [POS_W-1:0]   len;

    modport master (
        output restart, in_valid, in,
        input  out, err, err_pos, depth, len
    );

    modport slave (
        input  restart, in_valid, in,
        output out, err, err_pos, depth, len
    );

endinterface

// File: rtl/expr_stream_checker_char_class.sv
// Combinational ASCII classifier; '-' counts as an operator only when ALLOW_SUB is set.
module expr_char_class
    import expr_pkg::*;
#(
    parameter int ALLOW_SUB = 0
) (
    input  logic [7:0]  ch_i,
    output charClass_e  cls_o
);

    always_comb begin
        cls_o = CC_BAD;
        if (ch_i == ASCII_NUL)
            cls_o = CC_NUL;
        else if (ch_i == ASCII_0)
            cls_o = CC_ZERO;
        else if (ch_i > ASCII_0 && ch_i <= ASCII_9)
            cls_o = CC_NZ;
        else if (ch_i == ASCII_PLUS || ch_i == ASCII_STAR)
            cls_o = CC_OP;
        else if (ch_i == ASCII_MINUS && ALLOW_SUB != 0)
            cls_o = CC_OP;
        else if (ch_i == ASCII_LPAREN)
            cls_o = CC_OPEN;
        else if (ch_i == ASCII_RPAREN)
            cls_o = CC_CLOSE;
    end

endmodule

// File: rtl/expr_stream_checker.sv
// Streaming validator for ASCII arithmetic expressions (expr := term (op term)*,
// term := number | '(' expr ')'), one byte per clock, with sticky error reporting.
module expr_stream_checker
    import expr_pkg::*;
#(
    parameter int MAX_DIGITS = 2,
    parameter int MAX_DEPTH  = 4,
    parameter int ALLOW_SUB  = 0,
    parameter int POS_W      = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    expr_stream_checker_if.slave  bus
);

    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
    localparam int DCNT_W  = $clog2(MAX_DIGITS + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX  = DEPTH_W'(MAX_DEPTH);
    localparam logic [DCNT_W-1:0]  DIGITS_MAX = DCNT_W'(MAX_DIGITS);

    state_e             state_q, state_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [POS_W-1:0]   len_q, len_d;
    logic [POS_W-1:0]   errPos_q, errPos_d;
    logic               out_q, out_d;
    logic               err_q, err_d;
    logic               fault;
    charClass_e         cls;

    expr_char_class #(.ALLOW_SUB(ALLOW_SUB)) uClass (
        .ch_i  (bus.in),
        .cls_o (cls)
    );

    // Parser step: NUL and unqualified cycles leave everything untouched.
    always_comb begin
        state_d  = state_q;
        dcnt_d   = dcnt_q;
        depth_d  = depth_q;
        len_d    = len_q;
        errPos_d = errPos_q;
        out_d    = out_q;
        err_d    = err_q;
        fault    = 1'b0;

        if (bus.restart) begin
            state_d  = S_OPND;
            dcnt_d   = '0;
            depth_d  = '0;
            len_d    = '0;
            errPos_d = '0;
            out_d    = 1'b0;
            err_d    = 1'b0;
        end else if (bus.in_valid && cls != CC_NUL) begin
            if (len_q != '1)
                len_d = len_q + 1'b1;

            case (state_q)
                S_OPND: begin
                    case (cls)
                        CC_NZ: begin
                            state_d = S_NUM;
                            dcnt_d  = DCNT_W'(1);
                        end
                        CC_ZERO: state_d = S_ZERO;
                        CC_OPEN: begin
                            if (depth_q == DEPTH_MAX)
                                fault = 1'b1;
                            else
                                depth_d = depth_q + 1'b1;
                        end
                        default: fault = 1'b1;
                    endcase
                end
                S_NUM: begin
                    case (cls)
                        CC_NZ, CC_ZERO: begin
                            if (dcnt_q == DIGITS_MAX)
                                fault = 1'b1;
                            else
                                dcnt_d = dcnt_q + 1'b1;
                        end
                        CC_OP: state_d = S_OPND;
                        CC_CLOSE: begin
                            if (depth_q == '0)
                                fault = 1'b1;
                            else begin
                                depth_d = depth_q - 1'b1;
                                state_d = S_CLOSE;
                            end
                        end
                        default: fault = 1'b1;
                    endcase
                end
                S_ZERO, S_CLOSE: begin
                    case (cls)
                        CC_OP: state_d = S_OPND;
                        CC_CLOSE: begin
                            if (depth_q == '0)
                                fault = 1'b1;
                            else begin
                                depth_d = depth_q - 1'b1;
                                state_d = S_CLOSE;
                            end
                        end
                        default: fault = 1'b1;
                    endcase
                end
                default: ;
            endcase

            // Once in S_ERR only len keeps moving; the error snapshot stays frozen.
            if (state_q != S_ERR) begin
                if (fault) begin
                    state_d  = S_ERR;
                    err_d    = 1'b1;
                    errPos_d = len_q;
                    out_d    = 1'b0;
                    depth_d  = depth_q;
                    dcnt_d   = dcnt_q;
                end else begin
                    out_d = (state_d == S_NUM || state_d == S_ZERO || state_d == S_CLOSE)
                            && depth_d == '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= S_OPND;
            dcnt_q   <= '0;
            depth_q  <= '0;
            len_q    <= '0;
            errPos_q <= '0;
            out_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            depth_q  <= depth_d;
            len_q    <= len_d;
            errPos_q <= errPos_d;
            out_q    <= out_d;
            err_q    <= err_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.err     = err_q;
    assign bus.err_pos = errPos_q;
    assign bus.depth   = depth_q;
    assign bus.len     = len_q;

endmodule

// File: tb/tb_expr_stream_checker.sv
// Directed table-driven bench for expr_stream_checker; a second instance with
// ALLOW_SUB=1 sees the same stimulus and is checked on the '-' sequence.
module tb_expr_stream_checker;
    import expr_pkg::*;

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] c;
        logic       eOut;
        logic       eErr;
        logic [7:0] ePos;
        logic [2:0] eDepth;
        logic [7:0] eLen;
    } vec_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    expr_stream_checker_if #(.MAX_DEPTH(4), .POS_W(8)) busA ();
    expr_stream_checker_if #(.MAX_DEPTH(4), .POS_W(8)) busB ();

    expr_stream_checker #(.MAX_DIGITS(2), .MAX_DEPTH(4), .ALLOW_SUB(0), .POS_W(8)) dutA (
        .clk (clk),
        .clr (clr),
        .bus (busA)
    );

    expr_stream_checker #(.MAX_DIGITS(2), .MAX_DEPTH(4), .ALLOW_SUB(1), .POS_W(8)) dutB (
        .clk (clk),
        .clr (clr),
        .bus (busB)
    );

    task automatic addVec(input logic rst, input logic v, input logic [7:0] c,
                          input logic eOut, input logic eErr, input logic [7:0] ePos,
                          input logic [2:0] eDepth, input logic [7:0] eLen);
        vec_t t;
        t.rst = rst; t.v = v; t.c = c; t.eOut = eOut; t.eErr = eErr;
        t.ePos = ePos; t.eDepth = eDepth; t.eLen = eLen;
        vecs.push_back(t);
    endtask

    // Drive both instances at the falling edge, sample 1 ns after the rising edge.
    task automatic applyStimulus(input logic rst, input logic v, input logic [7:0] c);
        @(negedge clk);
        busA.restart = rst; busA.in_valid = v; busA.in = c;
        busB.restart = rst; busB.in_valid = v; busB.in = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input bit selB, input logic eOut,
                               input logic eErr, input logic [7:0] ePos,
                               input logic [2:0] eDepth, input logic [7:0] eLen);
        logic aOut, aErr;
        logic [7:0] aPos, aLen;
        logic [2:0] aDepth;
        aOut   = selB ? busB.out     : busA.out;
        aErr   = selB ? busB.err     : busA.err;
        aPos   = selB ? busB.err_pos : busA.err_pos;
        aDepth = selB ? busB.depth   : busA.depth;
        aLen   = selB ? busB.len     : busA.len;
        compared++;
        if (aOut !== eOut || aErr !== eErr || aPos !== ePos || aDepth !== eDepth || aLen !== eLen) begin
            mismatched++;
            $display("[TB] FAIL %s: got out=%b err=%b pos=%0d depth=%0d len=%0d, want out=%b err=%b pos=%0d depth=%0d len=%0d",
                     name, aOut, aErr, aPos, aDepth, aLen, eOut, eErr, ePos, eDepth, eLen);
        end
    endtask

    initial begin
        busA.restart = 1'b0; busA.in_valid = 1'b0; busA.in = 8'h00;
        busB.restart = 1'b0; busB.in_valid = 1'b0; busB.in = 8'h00;

        // "(12+3)*7"
        addVec(0,1,"(", 0,0,0,1,1);
        addVec(0,1,"1", 0,0,0,1,2);
        addVec(0,1,"2", 0,0,0,1,3);
        addVec(0,1,"+", 0,0,0,1,4);
        addVec(0,1,"3", 0,0,0,1,5);
        addVec(0,1,")", 1,0,0,0,6);
        addVec(0,1,"*", 0,0,0,0,7);
        addVec(0,1,"7", 1,0,0,0,8);
        // restart drops the concurrent character
        addVec(1,1,"9", 0,0,0,0,0);
        // "123+4": third digit overflows MAX_DIGITS
        addVec(0,1,"1", 1,0,0,0,1);
        addVec(0,1,"2", 1,0,0,0,2);
        addVec(0,1,"3", 0,1,2,0,3);
        addVec(0,1,"+", 0,1,2,0,4);
        addVec(0,1,"4", 0,1,2,0,5);
        // "(((((": fifth open exceeds MAX_DEPTH
        addVec(1,0,"0", 0,0,0,0,0);
        addVec(0,1,"(", 0,0,0,1,1);
        addVec(0,1,"(", 0,0,0,2,2);
        addVec(0,1,"(", 0,0,0,3,3);
        addVec(0,1,"(", 0,0,0,4,4);
        addVec(0,1,"(", 0,1,4,4,5);
        // "1)": close with depth 0
        addVec(1,0,"0", 0,0,0,0,0);
        addVec(0,1,"1", 1,0,0,0,1);
        addVec(0,1,")", 0,1,1,0,2);
        // "05": leading zero
        addVec(1,0,"0", 0,0,0,0,0);
        addVec(0,1,"0", 1,0,0,0,1);
        addVec(0,1,"5", 0,1,1,0,2);
        // "1+2" with idle cycles and NUL padding
        addVec(1,0,"0", 0,0,0,0,0);
        addVec(0,1,"1", 1,0,0,0,1);
        addVec(0,0,"X", 1,0,0,0,1);
        addVec(0,1,8'h00, 1,0,0,0,1);
        addVec(0,1,"+", 0,0,0,0,2);
        addVec(0,1,8'h00, 0,0,0,0,2);
        addVec(0,0,"7", 0,0,0,0,2);
        addVec(0,1,"2", 1,0,0,0,3);
        // restart with '5' drops it; next '5' accepted
        addVec(1,1,"5", 0,0,0,0,0);
        addVec(0,1,"5", 1,0,0,0,1);
        // illegal byte at the start
        addVec(1,0,"0", 0,0,0,0,0);
        addVec(0,1," ", 0,1,0,0,1);
        addVec(0,1,"1", 0,1,0,0,2);

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_state", 0, 0,0,0,0,0);
        clr = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].v, vecs[i].c);
            checkOutput($sformatf("vec%0d", i), 0, vecs[i].eOut, vecs[i].eErr,
                        vecs[i].ePos, vecs[i].eDepth, vecs[i].eLen);
        end

        // "3-4" on both instances: illegal without subtraction, valid with it
        applyStimulus(1, 0, "0");
        applyStimulus(0, 1, "3");
        applyStimulus(0, 1, "-");
        applyStimulus(0, 1, "4");
        checkOutput("sub_disabled", 0, 0,1,1,0,3);
        checkOutput("sub_enabled",  1, 1,0,0,0,3);

        // asynchronous clr in the middle of "(1+"
        applyStimulus(1, 0, "0");
        applyStimulus(0, 1, "(");
        applyStimulus(0, 1, "1");
        applyStimulus(0, 1, "+");
        checkOutput("pre_clr", 0, 0,0,0,1,3);
        @(negedge clk);
        busA.in_valid = 1'b0; busB.in_valid = 1'b0;
        clr = 1'b1;
        #1;
        checkOutput("async_clr", 0, 0,0,0,0,0);
        @(negedge clk);
        clr = 1'b0;
        applyStimulus(0, 1, "5");
        checkOutput("after_clr", 0, 1,0,0,0,1);

        // length saturation, then an error whose position saturates too
        applyStimulus(1, 0, "0");
        for (int k = 0; k < 300; k++)
            applyStimulus(0, 1, (k % 2 == 0) ? 8'h31 : 8'h2B);
        checkOutput("len_saturate", 0, 0,0,0,0,255);
        applyStimulus(0, 1, ")");
        checkOutput("pos_saturate", 0, 0,1,255,0,255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/expr_stream_checker.md
Name: expr_stream_checker

Overview:
- Streaming validator for ASCII arithmetic expressions arriving one byte per clock.
- Grammar: expr := term (op term)*; term := number | '(' expr ')'.
- Generalises the fixed two-digit, single-level recogniser with parametrised digit count, nesting depth, optional '-' operator, input qualification, restart, and error-position reporting.
- Sits after the character source (UART/testbench byte feed); its flags drive status LEDs and the checker scoreboard.

Parameters:
- MAX_DIGITS, 2: maximum digits per number, >=1.
- MAX_DEPTH, 4: maximum parenthesis nesting depth, >=1.
- ALLOW_SUB, 0: 1 = '-' accepted as a binary operator, 0 = '-' is illegal.
- POS_W, 8: width of the position counters.

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  asynchronous active-high reset.
- restart  input  1  synchronous stream restart; same effect as clr, applied at the clock edge.
- in_valid  input  1  qualifies in for this cycle.
- in  input  8  ASCII character.
- out  output  1  stream so far is a complete valid expression.
- err  output  1  sticky; a grammar, depth or length violation has occurred.
- err_pos  output  POS_W  index (0-based) of the first offending character.
- depth  output  clog2(MAX_DEPTH+1)  current open-parenthesis count.
- len  output  POS_W  number of accepted non-NUL characters, saturating at all-ones.

Behaviour:
- Reset (clr high, or restart at a clock edge):
  - state = S_OPND; out, err, err_pos, depth, len all 0.
  - clr overrides restart. restart overrides in_valid in the same cycle; that character is dropped.
- A character is consumed only when in_valid=1.
- NUL (8'h00) is padding: ignored in every state; len not incremented.
- All outputs are registered. Effect of a character accepted at edge N is visible after edge N.
- Character classes:
  - digit = '0'..'9'; nzdigit = '1'..'9'.
  - op = '+' or '*', plus '-' when ALLOW_SUB=1.
  - open = '('; close = ')'; any other byte is illegal.
- States and transitions (dcnt = digits in the current number):
  - S_OPND (expecting operand):
    - nzdigit -> S_NUM, dcnt=1.
    - '0' -> S_ZERO.
    - open -> depth+1, stay in S_OPND; if depth==MAX_DEPTH, error instead.
    - anything else -> error.
  - S_NUM:
    - digit -> dcnt+1, stay; if dcnt==MAX_DIGITS, error.
    - op -> S_OPND.
    - close -> S_CLOSE with depth-1; if depth==0, error.
    - else -> error.
  - S_ZERO (leading zero forbidden): op -> S_OPND; close -> same as S_NUM; anything else (including a digit) -> error.
  - S_CLOSE: op -> S_OPND; close -> same as S_NUM; else -> error.
  - S_ERR: absorbing until clr/restart. Characters are still counted in len; outputs are otherwise frozen.
- On error:
  - state = S_ERR, err=1.
  - err_pos = len value before the offending character is counted.
  - depth holds its pre-error value.
- out = 1 iff next state is S_NUM, S_ZERO or S_CLOSE, depth==0 and no error; otherwise 0.
  - out is updated only on consumed characters; it holds across idle and NUL cycles.
- len saturation: further characters are still parsed; err_pos saturates identically.
- Depth counter never wraps; overflow and underflow are errors, as defined above.
- The implementation is a single clocked process plus combinational next-state logic. No latches.

Decomposition:
- Shared package expr_pkg:
  - state enum {S_OPND, S_NUM, S_ZERO, S_CLOSE, S_ERR}.
  - ASCII constants for '0', '9', '(', ')', '+', '*', '-', NUL.
  - Character-class enum {CC_NZ, CC_ZERO, CC_OP, CC_OPEN, CC_CLOSE, CC_NUL, CC_BAD}.
- One combinational sub-module, expr_char_class: maps in plus ALLOW_SUB to the class enum. Reusable by later tokenizers.

Test Plan:
- Defaults; feed "(12+3)*7" with in_valid=1 continuously -> out=1 only after ')' and after '7'; err=0, depth=0, len=8.
- Feed "123" with MAX_DIGITS=2 -> out=1 after "12"; third char: err=1, err_pos=2, out=0. Later characters: len increments, err_pos stays 2.
- Feed "((((( 1" with MAX_DEPTH=4 -> 5th '(' gives err=1, err_pos=4, depth=4. Feed "1)" -> err=1, err_pos=1.
- Feed "0" then "5" -> out=1 after '0'; err=1, err_pos=1 after '5'. Feed "3-4": ALLOW_SUB=0 -> err_pos=1; ALLOW_SUB=1 -> out=1, len=3.
- Interleave NUL bytes and in_valid=0 gaps in "1+2" -> result identical to the contiguous stream, len=3.
- Assert clr asynchronously mid-"(1+" -> outputs 0 immediately. restart together with in_valid='5' -> char dropped; next "5" gives out=1, len=1.
